// File: rtl/weight_fetch.sv
// weight_fetch: walks the layer-1 weight ROM and streams each word to the PE array via a prefetch FIFO.
// Optional feature: define WFETCH_CHKSUM_EN to build the running signed weight checksum on chksum.
module weight_fetch #(
  parameter int unsigned     ADDR_WIDTH   = 32,
  parameter int unsigned     DATA_WIDTH   = 256,
  parameter int unsigned     WEIGHT_WIDTH = 16,
  parameter int unsigned     NUM_WORDS    = 28,
  parameter longint unsigned BASE_ADDR    = 0,
  parameter longint unsigned ADDR_STRIDE  = 16,
  parameter int unsigned     IDX_WIDTH    = 5,
  parameter int unsigned     FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  input  logic [DATA_WIDTH-1:0] lut_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [IDX_WIDTH-1:0]  w_idx,
  output logic                  w_last,
  output logic [31:0]           chksum
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_WIDTH:0]    WORDS_C  = (IDX_WIDTH + 1)'(NUM_WORDS);
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);
  localparam logic [CNT_W:0]        DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]      PTR_MAX  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_C   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_C = ADDR_WIDTH'(ADDR_STRIDE);

  if (FIFO_DEPTH < 3) begin : g_bad_depth
    $error("weight_fetch: FIFO_DEPTH must be at least 3");
  end
  if ((1 << IDX_WIDTH) < NUM_WORDS) begin : g_bad_idx
    $error("weight_fetch: IDX_WIDTH too narrow for NUM_WORDS");
  end
  if ((DATA_WIDTH % WEIGHT_WIDTH) != 0) begin : g_bad_lanes
    $error("weight_fetch: DATA_WIDTH must be a multiple of WEIGHT_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;

  logic                    accept;
  logic                    issue;
  logic                    push;
  logic                    pop;

  logic [IDX_WIDTH:0]      issued;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [1:0]              pipe_vld;
  logic [IDX_WIDTH-1:0]    pipe_tag [2];
  logic [1:0]              inflight;
  logic [CNT_W:0]          occupancy;

  logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic [IDX_WIDTH-1:0]    fifo_idx  [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [CNT_W-1:0]        fifo_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign accept    = (state == IDLE) && start;
  assign inflight  = {1'b0, pipe_vld[0]} + {1'b0, pipe_vld[1]};
  assign occupancy = {1'b0, fifo_count} + {{(CNT_W - 1){1'b0}}, inflight};
  // Words still in the ROM pipe count against FIFO space so a push can never overflow.
  assign issue     = (state == RUN) && (issued < WORDS_C) && (occupancy < DEPTH_C);
  assign push      = pipe_vld[1];
  assign pop       = w_valid && w_ready;

  assign w_valid = (fifo_count != '0);
  assign w_data  = fifo_data[rd_ptr];
  assign w_idx   = fifo_idx[rd_ptr];
  assign w_last  = w_valid && (w_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (pop && w_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The ROM answers one edge after it samples lut_addr, so each tag rides two stages before its data is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued      <= '0;
      next_addr   <= BASE_C;
      lut_addr    <= '0;
      pipe_vld    <= '0;
      pipe_tag[0] <= '0;
      pipe_tag[1] <= '0;
    end else if (accept) begin
      issued    <= '0;
      next_addr <= BASE_C;
      pipe_vld  <= '0;
    end else begin
      pipe_vld    <= {pipe_vld[0], issue};
      pipe_tag[1] <= pipe_tag[0];
      if (issue) begin
        pipe_tag[0] <= issued[IDX_WIDTH-1:0];
        lut_addr    <= next_addr;
        next_addr   <= next_addr + STRIDE_C;
        issued      <= issued + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_idx[i]  <= '0;
      end
    end else if (accept) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= lut_data;
        fifo_idx[wr_ptr]  <= pipe_tag[1];
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef WFETCH_CHKSUM_EN
  localparam int unsigned LANES = DATA_WIDTH / WEIGHT_WIDTH;

  logic [31:0]             lane_sum;
  logic [WEIGHT_WIDTH-1:0] lane;

  always_comb begin
    lane_sum = '0;
    lane     = '0;
    for (int j = 0; j < LANES; j++) begin
      lane     = w_data[DATA_WIDTH-1-WEIGHT_WIDTH*j -: WEIGHT_WIDTH];
      lane_sum = lane_sum + {{(32 - WEIGHT_WIDTH){lane[WEIGHT_WIDTH-1]}}, lane};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chksum <= '0;
    end else if (accept) begin
      chksum <= '0;
    end else if (pop) begin
      chksum <= chksum + lane_sum;
    end
  end
`else
  assign chksum = '0;
`endif

endmodule

// File: tb/tb_weight_fetch.sv
// tb_weight_fetch: directed bench for weight_fetch against a registered stub ROM.
// Expected checksums follow WFETCH_CHKSUM_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_weight_fetch;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int IW = 5;
  localparam int NW = 28;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic          w_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          w_valid;
  logic          w_last;
  logic [AW-1:0] lut_addr;
  logic [DW-1:0] lut_data;
  logic [DW-1:0] w_data;
  logic [IW-1:0] w_idx;
  logic [31:0]   chksum;

  weight_fetch dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .lut_addr(lut_addr),
    .lut_data(lut_data),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .w_data  (w_data),
    .w_idx   (w_idx),
    .w_last  (w_last),
    .chksum  (chksum)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int romMode   = 0;
  int expIdx    = 0;
  int wordCount = 0;
  int doneCount = 0;
  bit monEn     = 1'b0;
  bit prevStall = 1'b0;
  logic [DW-1:0] prevData;
  logic [IW-1:0] prevIdx;

  task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Stub ROM contents: pattern words with three lane-0 values pinned to the real ROM.
  function automatic logic [DW-1:0] romWord(input logic [AW-1:0] addr);
    logic [DW-1:0] w;
    logic [15:0]   lane;
    int            k;
    k = int'(addr >> 4);
    w = '0;
    for (int j = 0; j < 16; j++) begin
      if (romMode == 1) lane = 16'h0001;
      else if (romMode == 2) lane = 16'hFFFF;
      else lane = 16'((k * 305 + j * 71 + 3) ^ (j << 11));
      if (romMode == 0 && j == 0) begin
        if (k == 0) lane = 16'h0049;
        else if (k == 1) lane = 16'h0199;
        else if (k == 27) lane = 16'hFFA2;
      end
      w[DW-1-16*j -: 16] = lane;
    end
    return w;
  endfunction

  function automatic logic [31:0] expectedChksum();
    logic [31:0]   s;
    logic [DW-1:0] w;
    s = '0;
    for (int k = 0; k < NW; k++) begin
      w = romWord(32'(k * 16));
      for (int j = 0; j < 16; j++) begin
        s = s + {{16{w[DW-1-16*j]}}, w[DW-1-16*j -: 16]};
      end
    end
`ifdef WFETCH_CHKSUM_EN
    return s;
`else
    return (s == 32'hFFFF_FFFF) ? 32'd1 : 32'd0;
`endif
  endfunction

  function automatic logic readyFor(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return (n >= 12 && n < 22) ? 1'b0 : ((n % 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) lut_data <= romWord(lut_addr);

  // Scoreboard: every handshake is compared to the next ascending ROM word; stalled heads must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevStall = 1'b0;
    end else if (monEn) begin
      if (prevStall) begin
        checkOutput("stall_valid", w_valid, 1);
        checkOutput("stall_data", w_data, prevData);
        checkOutput("stall_idx", w_idx, prevIdx);
      end
      if (w_valid && w_ready) begin
        checkOutput("word_idx", w_idx, expIdx);
        checkOutput("word_data", w_data, romWord(32'(expIdx * 16)));
        checkOutput("word_last", w_last, (expIdx == NW - 1));
        if (romMode == 0 && expIdx == 0) checkOutput("lane0_w0", w_data[DW-1 -: 16], 16'h0049);
        if (romMode == 0 && expIdx == 1) checkOutput("lane0_w1", w_data[DW-1 -: 16], 16'h0199);
        if (romMode == 0 && expIdx == 27) checkOutput("lane0_w27", w_data[DW-1 -: 16], 16'hFFA2);
        expIdx++;
        wordCount++;
      end
      if (done) doneCount++;
      prevStall = w_valid && !w_ready;
      prevData  = w_data;
      prevIdx   = w_idx;
    end
  end

  task automatic applyStimulus(input int mode, input bit pokeStart, input int abortAt,
                               input int maxCycles, output int doneAt);
    doneAt    = -1;
    expIdx    = 0;
    wordCount = 0;
    doneCount = 0;
    monEn     = 1'b1;
    @(posedge clk); #1;
    start   = 1'b1;
    w_ready = readyFor(mode, 0);
    @(posedge clk); #1;
    for (int n = 0; n < maxCycles; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      start   = 1'b0;
      w_ready = readyFor(mode, n);
      if (n == 1) checkOutput("addr_first", lut_addr, 0);
      if (n == 2) checkOutput("valid_early", w_valid, 0);
      if (n == 3) checkOutput("valid_e3", w_valid, 1);
      if (pokeStart && (n == 10 || done)) start = 1'b1;
      if (done && doneAt < 0) doneAt = n;
      if (abortAt >= 0 && wordCount >= abortAt) break;
      if (doneAt >= 0 && n >= doneAt + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_addr"}, lut_addr, 0);
    checkOutput({tag, "_valid"}, w_valid, 0);
    checkOutput({tag, "_data"}, w_data, 0);
    checkOutput({tag, "_idx"}, w_idx, 0);
    checkOutput({tag, "_last"}, w_last, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_chksum"}, chksum, 0);
  endtask

  initial begin
    int doneAt;
    $display("[TB] weight_fetch bench starting");
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("rst");
    rst_n = 1'b1;

    romMode = 0;
    applyStimulus(0, 1'b0, -1, 60, doneAt);
    checkOutput("p1_done_cycle", doneAt, 31);
    checkOutput("p1_words", wordCount, NW);
    checkOutput("p1_done_count", doneCount, 1);
    checkOutput("p1_busy_after", busy, 0);
    checkOutput("p1_chksum", chksum, expectedChksum());

    applyStimulus(1, 1'b0, -1, 150, doneAt);
    checkOutput("p2_words", wordCount, NW);
    checkOutput("p2_done_count", doneCount, 1);
    checkOutput("p2_chksum", chksum, expectedChksum());

    applyStimulus(0, 1'b1, -1, 60, doneAt);
    checkOutput("p3_words", wordCount, NW);
    checkOutput("p3_done_count", doneCount, 1);
    checkOutput("p3_busy_after", busy, 0);

    applyStimulus(0, 1'b0, 11, 60, doneAt);
    checkOutput("p4_words_before_reset", wordCount, 11);
    rst_n = 1'b0;
    #1;
    checkResetValues("midrst");
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("midrst_hold");
    rst_n = 1'b1;
    applyStimulus(0, 1'b0, -1, 60, doneAt);
    checkOutput("p4_words", wordCount, NW);
    checkOutput("p4_done_cycle", doneAt, 31);

    applyStimulus(2, 1'b0, -1, 40, doneAt);
    checkOutput("p5_done_count", doneCount, 0);
    checkOutput("p5_words", wordCount, 0);
    checkOutput("p5_busy", busy, 1);
    checkOutput("p5_valid", w_valid, 1);
    checkOutput("p5_head_idx", w_idx, 0);
    checkOutput("p5_last_addr", lut_addr, 48);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    romMode = 1;
    applyStimulus(0, 1'b0, -1, 60, doneAt);
    checkOutput("p6_words", wordCount, NW);
`ifdef WFETCH_CHKSUM_EN
    checkOutput("p6_chksum", chksum, 32'd448);
`else
    checkOutput("p6_chksum", chksum, 32'd0);
`endif

    romMode = 2;
    applyStimulus(0, 1'b0, -1, 60, doneAt);
    checkOutput("p7_words", wordCount, NW);
`ifdef WFETCH_CHKSUM_EN
    checkOutput("p7_chksum", chksum, 32'hFFFF_FE40);
`else
    checkOutput("p7_chksum", chksum, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_fetch.md
# weight_fetch

Sequencer that reads the layer-1 weight ROM word by word and streams each 256-bit word to the PE array. It sits directly downstream of the weight ROM and drives its address port. It absorbs the ROM's fixed read latency and PE back-pressure through a small prefetch FIFO, so it delivers one word per cycle whenever the consumer is ready.

## Interface
- ADDR_WIDTH, 32, ROM address width
- DATA_WIDTH, 256, ROM word width (16 lanes × 16 bits)
- WEIGHT_WIDTH, 16, lane width; signed two's complement
- NUM_WORDS, 28, words per pass (ROM addresses 0..432)
- BASE_ADDR, 0, address of word 0
- ADDR_STRIDE, 16, address increment per word
- IDX_WIDTH, 5, width of the word index; must satisfy 2^IDX_WIDTH ≥ NUM_WORDS
- FIFO_DEPTH, 4, prefetch FIFO entries; must be ≥ 3
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a pass (honoured only in IDLE)
- busy  out  1  high from start acceptance through the DONE cycle
- done  out  1  one-cycle pulse after the last word handshake
- lut_addr  out  ADDR_WIDTH  registered ROM address
- lut_data  in  DATA_WIDTH  ROM read data
- w_valid  out  1  FIFO head valid
- w_ready  in  1  consumer accepts the head this cycle
- w_data  out  DATA_WIDTH  FIFO head word; lane j = w_data[DATA_WIDTH-1-16j -: 16], so lane 0 is the MSBs
- w_idx  out  IDX_WIDTH  word index (0..NUM_WORDS-1) of the head
- w_last  out  1  head is word NUM_WORDS-1
- chksum  out  32  weight checksum (see Configuration)

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- IDLE → RUN when start=1. On this transition: issue counter, delivered counter and FIFO are cleared.
- RUN, issue rule: a read issues in a cycle when issued < NUM_WORDS and fifo_count + inflight < FIFO_DEPTH.
  - On an issue, lut_addr ← BASE_ADDR + issued×ADDR_STRIDE, computed modulo 2^ADDR_WIDTH.
  - The issue tag (the word index) enters a 2-stage in-flight pipe.
- ROM contract: the ROM samples lut_addr on one edge and presents lut_data after that edge.
  - So a tag leaving the pipe writes lut_data and its index into the FIFO tail.
  - inflight counts tags in the pipe (0..2).
- Handshake: a word transfers when w_valid & w_ready. On transfer:
  - FIFO pops;
  - delivered increments;
  - the handshake with w_last=1 moves the FSM RUN → DONE.
- Simultaneous push and pop in one cycle are both performed; fifo_count is unchanged.
- DONE: done=1 for exactly one cycle, then the FSM goes to IDLE. busy drops together with the return to IDLE.
- start while busy, including the DONE cycle: ignored; no effect on the pass.
- w_data, w_idx and w_last are meaningful only while w_valid=1. They hold steady while w_valid=1 and w_ready=0.
- Word order is strictly ascending address. No word is dropped or duplicated under any w_ready pattern.
- Reset mid-pass: all state returns to IDLE immediately; the pass is abandoned and the next start begins again at word 0.

## Timing
- Reset values: lut_addr=0, w_valid=0, w_data=0, w_idx=0, w_last=0, busy=0, done=0, chksum=0.
- Let edge E be the edge that samples start=1 in IDLE.
  - lut_addr=BASE_ADDR after edge E+1.
  - Word 0 is captured into the FIFO at edge E+3; w_valid is high from then on.
- With w_ready held at 1: one word per cycle. Last handshake at edge E+3+NUM_WORDS; done is high in the following cycle.
- Back-pressure latency: w_ready=0 stalls issue once fifo_count + inflight reaches FIFO_DEPTH.
- Restart latency: after w_ready returns to 1, w_valid never drops while words remain in the FIFO or in flight.

## Configuration
- WFETCH_CHKSUM_EN defined:
  - chksum is cleared on start acceptance;
  - on each handshake it adds the sign-extended sum of the 16 lanes of w_data, wrapping modulo 2^32;
  - the final value is valid from the done cycle and is held until the next start.
- WFETCH_CHKSUM_EN not defined: chksum is tied to 0 and no adder logic is built.

## Test plan
- Real ROM, w_ready=1, one start → lut_addr steps 0,16,…,432.
  - 28 handshakes with w_idx 0..27.
  - Word 0 lane 0 = 0x0049; word 1 lane 0 = 0x0199; word 27 lane 0 = 0xFFA2, with w_last=1.
  - done pulses once, in cycle E+32.
- w_ready toggling 1-0-1-0, plus a 10-cycle hold at 0 mid-pass → identical 28-word sequence.
  - Outputs stable during stalls.
  - fifo_count never exceeds 4 and lut_addr never advances while the FIFO and pipe are full.
- start pulsed in RUN and again in the DONE cycle → ignored; exactly 28 words and one done pulse.
- rst_n asserted after word 10 handshakes, then released, then start → all outputs at reset values while reset is held; new pass begins at word 0 with lut_addr=0.
- Stub ROM returning every lane = 0x0001, WFETCH_CHKSUM_EN defined → chksum=448 at done.
  - Same run with every lane = 0xFFFF → chksum=0xFFFFFE40.
  - With the macro undefined → chksum=0 throughout.
- start with w_ready=0 for the whole pass → w_valid high from E+3; exactly 4 words prefetched; busy stays 1 and done never asserts.
